// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the load/store unit.
// It runs one transaction at a time, shapes byte lanes for stores and extends load data.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req_i,
  input  logic [31:0] ifetch_addr_i,
  input  logic        ifetch_flush_i,
  output logic        ifetch_gnt_o,
  output logic        ifetch_rvalid_o,
  output logic [31:0] ifetch_rdata_o,
  input  logic        lsu_req_i,
  input  logic [3:0]  lsu_func_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [3:0] FN_LW  = 4'd1;
  localparam logic [3:0] FN_LH  = 4'd2;
  localparam logic [3:0] FN_LB  = 4'd3;
  localparam logic [3:0] FN_LHU = 4'd4;
  localparam logic [3:0] FN_LBU = 4'd5;
  localparam logic [3:0] FN_SW  = 4'd6;
  localparam logic [3:0] FN_SH  = 4'd7;
  localparam logic [3:0] FN_SB  = 4'd8;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  starve_q;
  logic        drop_q;
  logic        is_if_q;
  logic [3:0]  func_q;
  logic [1:0]  off_q;

  logic        is_load, is_store, lsu_valid, starved;
  logic        if_win, lsu_win, misaligned;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_ifetch_lsb;

  assign unused_ifetch_lsb = ^ifetch_addr_i[1:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    lsu_be     = 4'b1111;
    lsu_wdata  = lsu_wdata_i;
    case (lsu_func_i)
      FN_LW, FN_SW: misaligned = (lsu_addr_i[1:0] != 2'b00);
      FN_LH, FN_LHU, FN_SH: begin
        misaligned = lsu_addr_i[0];
        lsu_be     = 4'b0011 << {lsu_addr_i[1], 1'b0};
        lsu_wdata  = {2{lsu_wdata_i[15:0]}};
      end
      FN_LB, FN_LBU, FN_SB: begin
        lsu_be    = 4'b0001 << lsu_addr_i[1:0];
        lsu_wdata = {4{lsu_wdata_i[7:0]}};
      end
      default: ;
    endcase
    case (lsu_func_i)
      FN_LW, FN_LH, FN_LB, FN_LHU, FN_LBU: is_load = 1'b1;
      FN_SW, FN_SH, FN_SB:                 is_store = 1'b1;
      default: ;
    endcase
  end

  // NOP and undefined function codes never compete for the port.
  assign lsu_valid = lsu_req_i && (is_load || is_store);
  assign starved   = (starve_q == LIMIT);
  assign if_win    = (state_q == S_IDLE) && ifetch_req_i && (!lsu_valid || starved);
  assign lsu_win   = (state_q == S_IDLE) && lsu_valid && !(ifetch_req_i && starved);

  assign ifetch_gnt_o     = if_win;
  assign lsu_gnt_o        = lsu_win;
  assign lsu_misaligned_o = lsu_win && misaligned;

  always_comb begin
    ld_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (func_q)
      FN_LW:   ld_data = mem_rdata_i;
      FN_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      FN_LHU:  ld_data = {16'h0000, ld_half};
      FN_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      FN_LBU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      starve_q        <= 4'd0;
      drop_q          <= 1'b0;
      is_if_q         <= 1'b0;
      func_q          <= 4'd0;
      off_q           <= 2'd0;
      ifetch_rvalid_o <= 1'b0;
      ifetch_rdata_o  <= 32'h0;
      lsu_rvalid_o    <= 1'b0;
      lsu_rdata_o     <= 32'h0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_be_o        <= 4'b0000;
      mem_addr_o      <= 32'h0;
      mem_wdata_o     <= 32'h0;
    end else begin
      ifetch_rvalid_o <= 1'b0;
      lsu_rvalid_o    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_win) begin
            starve_q    <= 4'd0;
            drop_q      <= ifetch_flush_i;
            is_if_q     <= 1'b1;
            func_q      <= 4'd0;
            off_q       <= 2'd0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b1111;
            mem_addr_o  <= {ifetch_addr_i[31:2], 2'b00};
            mem_wdata_o <= 32'h0;
            state_q     <= S_REQ;
          end else if (lsu_win && !misaligned) begin
            if (!ifetch_req_i)
              starve_q <= 4'd0;
            else if (!starved)
              starve_q <= starve_q + 4'd1;
            drop_q      <= 1'b0;
            is_if_q     <= 1'b0;
            func_q      <= lsu_func_i;
            off_q       <= lsu_addr_i[1:0];
            mem_req_o   <= 1'b1;
            mem_we_o    <= is_store;
            mem_be_o    <= lsu_be;
            mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            mem_wdata_o <= is_store ? lsu_wdata : 32'h0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (is_if_q && ifetch_flush_i)
            drop_q <= 1'b1;
          if (mem_gnt_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (is_if_q && ifetch_flush_i)
            drop_q <= 1'b1;
          if (mem_rvalid_i) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            // A flush arriving with the response still discards it.
            if (is_if_q) begin
              if (!drop_q && !ifetch_flush_i) begin
                ifetch_rvalid_o <= 1'b1;
                ifetch_rdata_o  <= mem_rdata_i;
              end
            end else begin
              lsu_rvalid_o <= 1'b1;
              lsu_rdata_o  <= ld_data;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected grants, memory
// requests and responses; independent monitors pop and compare as the DUT emits them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam logic [3:0] FN_LW = 4'd1, FN_LH = 4'd2, FN_LB = 4'd3, FN_LHU = 4'd4;
  localparam logic [3:0] FN_LBU = 4'd5, FN_SW = 4'd6, FN_SH = 4'd7, FN_SB = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_req_i = 1'b0, ifetch_flush_i = 1'b0;
  logic [31:0] ifetch_addr_i = 32'h0;
  logic        ifetch_gnt_o, ifetch_rvalid_o;
  logic [31:0] ifetch_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic [3:0]  lsu_func_i = 4'd0;
  logic [31:0] lsu_addr_i = 32'h0, lsu_wdata_i = 32'h0;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_misaligned_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ifetch_req_i(ifetch_req_i), .ifetch_addr_i(ifetch_addr_i), .ifetch_flush_i(ifetch_flush_i),
    .ifetch_gnt_o(ifetch_gnt_o), .ifetch_rvalid_o(ifetch_rvalid_o), .ifetch_rdata_o(ifetch_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_func_i(lsu_func_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_misaligned_o(lsu_misaligned_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct { logic is_if; logic mis; } gnt_t;
  typedef struct { logic is_if; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } mem_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  mem_t exp_mem[$];

  int          checks = 0, errors = 0;
  int          gnt_delay = 0, rsp_delay = 0;
  logic [31:0] rd_word = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Memory model: grants after gnt_delay cycles, responds rsp_delay cycles after that.
  initial begin : responder
    int   wait_cnt = 0, rsp_wait = 0;
    bit   pend = 0;
    logic [31:0] pdata = 32'h0;
    mem_t m;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (pend) begin
        if (rsp_wait == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = pdata;
          pend = 0;
        end else rsp_wait--;
      end else if (mem_req_o) begin
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          wait_cnt = 0; mem_gnt_i = 1'b1; pend = 1; rsp_wait = rsp_delay; pdata = rd_word;
          if (exp_mem.size() == 0) fail("mem_unexpected", $sformatf("request addr=%h", mem_addr_o));
          else begin
            m = exp_mem.pop_front();
            chk("mem_we", mem_we_o, m.we);
            chk("mem_be", mem_be_o, m.be);
            chk("mem_addr", mem_addr_o, m.addr);
            chk("mem_wdata", mem_wdata_o, m.wdata);
            $display("mem  addr=%h we=%b be=%b wdata=%h", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
          end
        end
      end
    end
  end

  initial begin : gnt_mon
    gnt_t g;
    forever begin
      @(negedge clk); #2;
      if (!rst && (ifetch_gnt_o || lsu_gnt_o)) begin
        if (ifetch_gnt_o && lsu_gnt_o) fail("dual_grant", "both grants high");
        else if (exp_gnt.size() == 0) fail("gnt_unexpected", $sformatf("if=%b lsu=%b", ifetch_gnt_o, lsu_gnt_o));
        else begin
          g = exp_gnt.pop_front();
          chk("gnt_is_if", ifetch_gnt_o, g.is_if);
          chk("gnt_misaligned", lsu_misaligned_o, g.mis);
          $display("gnt  if=%b lsu=%b mis=%b", ifetch_gnt_o, lsu_gnt_o, lsu_misaligned_o);
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t r;
    forever begin
      @(negedge clk); #2;
      if (!rst && (ifetch_rvalid_o || lsu_rvalid_o)) begin
        if (ifetch_rvalid_o && lsu_rvalid_o) fail("dual_rvalid", "both rvalid high");
        else if (exp_rsp.size() == 0) fail("rsp_unexpected", $sformatf("if=%b lsu=%b", ifetch_rvalid_o, lsu_rvalid_o));
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_is_if", ifetch_rvalid_o, r.is_if);
          chk("rsp_rdata", ifetch_rvalid_o ? ifetch_rdata_o : lsu_rdata_o, r.data);
          $display("rsp  if=%b data=%h", ifetch_rvalid_o, ifetch_rvalid_o ? ifetch_rdata_o : lsu_rdata_o);
        end
      end
    end
  end

  task automatic wait_gnt(input bit want_if);
    int n = 0;
    #1;
    while (!(want_if ? ifetch_gnt_o : lsu_gnt_o) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) fail("grant_timeout", want_if ? "ifetch" : "lsu");
  endtask

  task automatic lsu_txn(input logic [3:0] fn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic mis, input logic [3:0] be, input logic [31:0] mwdata,
                         input logic [31:0] rdata);
    logic st;
    st = (fn == FN_SW) || (fn == FN_SH) || (fn == FN_SB);
    exp_gnt.push_back('{1'b0, mis});
    if (!mis) begin
      exp_mem.push_back('{st, be, {addr[31:2], 2'b00}, mwdata});
      exp_rsp.push_back('{1'b0, rdata});
    end
    @(negedge clk);
    lsu_func_i = fn; lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_req_i = 1'b1;
    wait_gnt(1'b0);
    @(negedge clk);
    lsu_req_i = 1'b0;
  endtask

  task automatic if_txn(input logic [31:0] addr, input logic [31:0] data, input bit flush);
    exp_gnt.push_back('{1'b1, 1'b0});
    exp_mem.push_back('{1'b0, 4'b1111, addr, 32'h0});
    if (!flush) exp_rsp.push_back('{1'b1, data});
    @(negedge clk);
    ifetch_addr_i = addr; ifetch_req_i = 1'b1;
    wait_gnt(1'b1);
    @(negedge clk);
    ifetch_req_i = 1'b0;
    if (flush) begin
      ifetch_flush_i = 1'b1;
      @(negedge clk);
      ifetch_flush_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_gnt.size() + exp_mem.size() + exp_rsp.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) fail("drain_timeout", "expected traffic did not appear");
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ifetch_gnt"}, ifetch_gnt_o, 0);
    chk({tag, "_ifetch_rvalid"}, ifetch_rvalid_o, 0);
    chk({tag, "_ifetch_rdata"}, ifetch_rdata_o, 0);
    chk({tag, "_lsu_gnt"}, {lsu_gnt_o, lsu_misaligned_o}, 0);
    chk({tag, "_lsu_rvalid"}, lsu_rvalid_o, 0);
    chk({tag, "_lsu_rdata"}, lsu_rdata_o, 0);
    chk({tag, "_mem_ctrl"}, {mem_req_o, mem_we_o, mem_be_o}, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
  endtask

  initial begin : main
    int lat, n, got;
    repeat (3) @(negedge clk);
    #2 check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    rd_word = 32'hDEADBEEF;
    lsu_txn(FN_LW, 32'h104, 32'h0, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
    lat = 1;
    do begin
      @(negedge clk); #2; lat++;
    end while (!lsu_rvalid_o && lat < 20);
    chk("lw_latency", lat, 3);
    drain();

    rd_word = 32'h80FF0000;
    lsu_txn(FN_LB,  32'h103, 32'h0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80); drain();
    lsu_txn(FN_LBU, 32'h103, 32'h0, 1'b0, 4'b1000, 32'h0, 32'h00000080); drain();
    lsu_txn(FN_LH,  32'h102, 32'h0, 1'b0, 4'b1100, 32'h0, 32'hFFFF80FF); drain();
    lsu_txn(FN_LHU, 32'h102, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h000080FF); drain();
    lsu_txn(FN_LB,  32'h101, 32'h0, 1'b0, 4'b0010, 32'h0, 32'h00000000); drain();

    lsu_txn(FN_SB, 32'h101, 32'h000000A5, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0); drain();
    lsu_txn(FN_SH, 32'h102, 32'hCAFE1234, 1'b0, 4'b1100, 32'h12341234, 32'h0); drain();
    lsu_txn(FN_SW, 32'h108, 32'h01020304, 1'b0, 4'b1111, 32'h01020304, 32'h0); drain();

    lsu_txn(FN_LW,  32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    lsu_txn(FN_SH,  32'h103, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    lsu_txn(FN_LHU, 32'h101, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    drain();

    // Both sides requesting continuously: four LSU grants, then IF, repeating.
    rd_word = 32'h12345678;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        exp_gnt.push_back('{1'b1, 1'b0});
        exp_mem.push_back('{1'b0, 4'b1111, 32'h500, 32'h0});
        exp_rsp.push_back('{1'b1, 32'h12345678});
      end else begin
        exp_gnt.push_back('{1'b0, 1'b0});
        exp_mem.push_back('{1'b0, 4'b1111, 32'h200, 32'h0});
        exp_rsp.push_back('{1'b0, 32'h12345678});
      end
    end
    @(negedge clk);
    ifetch_addr_i = 32'h500; ifetch_req_i = 1'b1;
    lsu_func_i = FN_LW; lsu_addr_i = 32'h200; lsu_req_i = 1'b1;
    n = 0; got = 0;
    do begin
      #1;
      if (ifetch_gnt_o || lsu_gnt_o) got++;
      if (got < 10) begin
        @(negedge clk); n++;
      end
    end while (got < 10 && n < 200);
    if (n >= 200) fail("starve_timeout", "grant sequence stalled");
    @(negedge clk);
    ifetch_req_i = 1'b0; lsu_req_i = 1'b0;
    drain();

    gnt_delay = 3;
    if_txn(32'h300, 32'h0, 1'b1);
    drain();
    gnt_delay = 0;
    rd_word = 32'h00000013;
    if_txn(32'h304, 32'h00000013, 1'b0);
    drain();

    // Reset while waiting in RESP; the late memory response must be ignored.
    rsp_delay = 3;
    exp_gnt.push_back('{1'b1, 1'b0});
    exp_mem.push_back('{1'b0, 4'b1111, 32'h600, 32'h0});
    @(negedge clk);
    ifetch_addr_i = 32'h600; ifetch_req_i = 1'b1;
    wait_gnt(1'b1);
    @(negedge clk);
    ifetch_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2 check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    rsp_delay = 0;
    repeat (8) @(negedge clk);
    rd_word = 32'h0BADF00D;
    lsu_txn(FN_LW, 32'h700, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0BADF00D);
    drain();

    chk("left_gnt", exp_gnt.size(), 0);
    chk("left_mem", exp_mem.size(), 0);
    chk("left_rsp", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
